// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch controller.
package fetch_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} fetch_state_e;
  function automatic logic [INST_W-1:0] next_addr(input logic [INST_W-1:0] a);
    return a + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry instruction+PC buffer used while decode is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] load_inst,
  input  logic [INST_W-1:0] load_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] pc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      inst <= NOP_INST;
      pc <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst <= load_inst;
      pc <= load_pc;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences PC and a valid/ready instruction memory into IF/ID with one outstanding request.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] pc,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic [INST_W-1:0] redirect_pc,
  input  logic              pipe_stall,
  input  logic              br_taken,
  input  logic [INST_W-1:0] br_target,
  output logic              imem_req_valid,
  output logic [INST_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [INST_W-1:0] if_pc,
  output logic              if_bubble
);
  fetch_state_e state;
  logic [INST_W-1:0] req_pc, hold_inst, hold_pc;
  logic hold_valid, hold_load, hold_clear, deliver_wait, deliver_hold;

  fetch_hold_buf u_hold (
    .clk(clk),
    .rst(rst),
    .load(hold_load),
    .clear(hold_clear),
    .load_inst(imem_rsp_data),
    .load_pc(req_pc),
    .valid(hold_valid),
    .inst(hold_inst),
    .pc(hold_pc)
  );

  // A redirect suppresses delivery and new requests; the PC takes br_target instead.
  always_comb begin
    deliver_wait = state == WAIT && imem_rsp_valid && !pipe_stall && !br_taken;
    deliver_hold = state == HOLD && hold_valid && !pipe_stall && !br_taken;
    hold_load = state == WAIT && imem_rsp_valid && pipe_stall && !br_taken;
    hold_clear = state == HOLD && (br_taken || !pipe_stall);
    if_valid = deliver_wait || deliver_hold;
    if_bubble = !if_valid;
    if_inst = deliver_wait ? imem_rsp_data : deliver_hold ? hold_inst : NOP_INST;
    if_pc = deliver_wait ? req_pc : deliver_hold ? hold_pc : '0;
    imem_req_valid = !br_taken && (state == REQ || deliver_wait);
    imem_req_addr = deliver_wait ? next_addr(req_pc) : imem_req_valid ? pc : '0;
    pc_redirect = br_taken;
    redirect_pc = br_taken ? br_target : '0;
    pc_stall = !br_taken && !if_valid;
  end

  // A redirect in DRAIN that coincides with the stale response leaves nothing outstanding.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      req_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ:
          if (!br_taken && imem_req_ready) begin
            state <= WAIT;
            req_pc <= pc;
          end
        WAIT:
          if (br_taken) state <= imem_rsp_valid ? REQ : DRAIN;
          else if (hold_load) state <= HOLD;
          else if (deliver_wait && imem_req_ready) req_pc <= next_addr(req_pc);
          else if (deliver_wait) state <= REQ;
        HOLD: if (hold_clear) state <= REQ;
        DRAIN: if (imem_rsp_valid) state <= REQ;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl against a PC register and variable-latency memory model.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc, redirect_pc, br_target, imem_req_addr, imem_rsp_data, if_inst, if_pc;
  logic pc_stall, pc_redirect, imem_req_valid, imem_req_ready, imem_rsp_valid, if_valid, if_bubble;
  logic pipe_stall = 1'b0;
  logic br_taken = 1'b0;
  logic mem_ready = 1'b1;
  logic mem_pend;
  logic [31:0] mem_addr;
  int mem_cnt, acc_cnt, dup_cnt;
  int mem_lat = 1;
  int tests = 0;
  int fails = 0;

  fetch_ctrl dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .pc_stall(pc_stall),
    .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc),
    .pipe_stall(pipe_stall),
    .br_taken(br_taken),
    .br_target(br_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid),
    .if_inst(if_inst),
    .if_pc(if_pc),
    .if_bubble(if_bubble)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) pc <= 32'h0;
    else if (pc_redirect) pc <= redirect_pc;
    else if (!pc_stall) pc <= pc + 32'd4;

  assign imem_req_ready = mem_ready;
  assign imem_rsp_valid = mem_pend && mem_cnt == 0;
  assign imem_rsp_data = {16'hC0DE, mem_addr[15:0]};

  always @(posedge clk or posedge rst)
    if (rst) begin
      mem_pend <= 1'b0;
      mem_cnt <= 0;
      mem_addr <= 32'h0;
      acc_cnt <= 0;
      dup_cnt <= 0;
    end else begin
      if (imem_rsp_valid) mem_pend <= 1'b0;
      else if (mem_pend) mem_cnt <= mem_cnt - 1;
      if (imem_req_valid && imem_req_ready) begin
        if (mem_pend && !imem_rsp_valid) dup_cnt <= dup_cnt + 1;
        acc_cnt <= acc_cnt + 1;
        mem_pend <= 1'b1;
        mem_addr <= imem_req_addr;
        mem_cnt <= mem_lat - 1;
      end
    end

  task automatic do_reset;
    rst = 1'b1;
    pipe_stall = 1'b0;
    br_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    br_target = 32'hDEAD_BEEC;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL reset_pc_stall: got %b want 1", pc_stall); end
    tests++; if (pc_redirect !== 1'b0 || redirect_pc !== 32'h0) begin fails++; $display("FAIL reset_redirect: got %b/%h want 0/0", pc_redirect, redirect_pc); end
    tests++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_req: got %b/%h want 0/0", imem_req_valid, imem_req_addr); end
    tests++; if (if_valid !== 1'b0 || if_bubble !== 1'b1) begin fails++; $display("FAIL reset_if_flags: got %b/%b want 0/1", if_valid, if_bubble); end
    tests++; if (if_inst !== 32'h13 || if_pc !== 32'h0) begin fails++; $display("FAIL reset_if_data: got %h/%h want 00000013/0", if_inst, if_pc); end
    br_target = 32'h0;
  endtask

  task automatic test_stream;
    mem_lat = 1; mem_ready = 1'b1; do_reset();
    @(negedge clk); #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL stream_first_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      tests++;
      if (if_valid !== 1'b1 || if_bubble !== 1'b0 || if_pc !== 32'(i * 4) || if_inst !== {16'hC0DE, 16'(i * 4)}) begin
        fails++; $display("FAIL stream_%0d: got v=%b b=%b pc=%h inst=%h want v=1 b=0 pc=%h", i, if_valid, if_bubble, if_pc, if_inst, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall;
    mem_lat = 1; mem_ready = 1'b1; do_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); pipe_stall = 1'b1; #1;
      tests++;
      if (if_valid !== 1'b0 || pc_stall !== 1'b1 || imem_req_valid !== 1'b0) begin
        fails++; $display("FAIL stall_hold_%0d: got v=%b pc_stall=%b req=%b want 0/1/0", i, if_valid, pc_stall, imem_req_valid);
      end
    end
    @(negedge clk); pipe_stall = 1'b0; #1;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'hC0DE0008 || pc_stall !== 1'b0) begin fails++; $display("FAIL stall_release: got v=%b pc=%h inst=%h pc_stall=%b want 1/8/c0de0008/0", if_valid, if_pc, if_inst, pc_stall); end
    @(negedge clk); #1;
    tests++; if (if_valid !== 1'b0 || pc !== 32'hC || imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin fails++; $display("FAIL stall_after: got v=%b pc=%h req=%b/%h want 0/c/1/c", if_valid, pc, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_drain;
    logic found, seen;
    logic [31:0] first_addr;
    mem_lat = 4; mem_ready = 1'b1; do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (imem_req_valid && imem_req_addr == 32'h10) found = 1'b1;
    end
    tests++; if (!found) begin fails++; $display("FAIL drain_setup: request for 0x10 got none want one within 40 cycles"); end
    @(negedge clk); br_taken = 1'b1; br_target = 32'h100; #1;
    tests++; if (pc_redirect !== 1'b1 || redirect_pc !== 32'h100 || pc_stall !== 1'b0) begin fails++; $display("FAIL drain_redirect: got %b/%h/%b want 1/100/0", pc_redirect, redirect_pc, pc_stall); end
    tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL drain_redirect_quiet: got v=%b req=%b want 0/0", if_valid, imem_req_valid); end
    @(negedge clk); br_taken = 1'b0; #1;
    tests++; if (pc_stall !== 1'b1 || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL drain_wait: got pc_stall=%b req=%b v=%b want 1/0/0", pc_stall, imem_req_valid, if_valid); end
    seen = 1'b0; found = 1'b0; first_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #1;
      if (imem_req_valid && !seen) begin seen = 1'b1; first_addr = imem_req_addr; end
      if (if_valid) found = 1'b1;
    end
    tests++; if (first_addr !== 32'h100) begin fails++; $display("FAIL drain_first_req: got %h want 100", first_addr); end
    tests++; if (!found || if_pc !== 32'h100 || if_inst !== 32'hC0DE0100) begin fails++; $display("FAIL drain_deliver: got found=%b pc=%h inst=%h want 1/100/c0de0100", found, if_pc, if_inst); end
  endtask

  task automatic test_br_with_rsp;
    mem_lat = 1; mem_ready = 1'b1; do_reset();
    repeat (2) @(negedge clk);
    @(negedge clk); br_taken = 1'b1; br_target = 32'h200; #1;
    tests++; if (if_valid !== 1'b0 || pc_redirect !== 1'b1 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL brrsp_cycle: got v=%b redir=%b req=%b want 0/1/0", if_valid, pc_redirect, imem_req_valid); end
    @(negedge clk); br_taken = 1'b0; #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin fails++; $display("FAIL brrsp_next_req: got %b/%h want 1/200", imem_req_valid, imem_req_addr); end
    @(negedge clk); #1;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin fails++; $display("FAIL brrsp_deliver: got %b/%h want 1/200", if_valid, if_pc); end
  endtask

  task automatic test_ready_low;
    mem_lat = 1; mem_ready = 1'b0; do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      tests++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || pc_stall !== 1'b1) begin
        fails++; $display("FAIL ready_low_%0d: got req=%b addr=%h pc_stall=%b want 1/0/1", i, imem_req_valid, imem_req_addr, pc_stall);
      end
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || acc_cnt !== 1 || dup_cnt !== 0) begin fails++; $display("FAIL ready_accept: got v=%b pc=%h acc=%0d dup=%0d want 1/0/1/0", if_valid, if_pc, acc_cnt, dup_cnt); end
  endtask

  task automatic test_wrap;
    mem_lat = 1; mem_ready = 1'b1; do_reset();
    @(negedge clk); br_taken = 1'b1; br_target = 32'hFFFF_FFFC; #1;
    tests++; if (pc_redirect !== 1'b1 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL wrap_redirect: got %b/%b want 1/0", pc_redirect, imem_req_valid); end
    @(negedge clk); br_taken = 1'b0; #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr); end
    @(negedge clk); #1;
    tests++; if (if_pc !== 32'hFFFF_FFFC || imem_req_addr !== 32'h0) begin fails++; $display("FAIL wrap_next: got pc=%h addr=%h want fffffffc/0", if_pc, imem_req_addr); end
    @(negedge clk); #1;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin fails++; $display("FAIL wrap_deliver: got %b/%h want 1/0", if_valid, if_pc); end
  endtask

  task automatic test_reset_mid;
    mem_lat = 1; mem_ready = 1'b1; do_reset();
    repeat (4) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    tests++; if (if_valid !== 1'b0 || if_bubble !== 1'b1 || if_inst !== 32'h13 || if_pc !== 32'h0) begin fails++; $display("FAIL rstmid_if: got v=%b b=%b inst=%h pc=%h want 0/1/13/0", if_valid, if_bubble, if_inst, if_pc); end
    tests++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || pc_stall !== 1'b1 || pc_redirect !== 1'b0) begin fails++; $display("FAIL rstmid_ctl: got req=%b addr=%h stall=%b redir=%b want 0/0/1/0", imem_req_valid, imem_req_addr, pc_stall, pc_redirect); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL rstmid_first_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
  endtask

  initial begin
    br_target = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_br_with_rsp();
    test_ready_low();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, want finish before 100000", $time);
    $fatal(1);
  end
endmodule
